blinker_switch_poller: RTL and testbench

//  Avalon-MM master that periodically polls the 8-bit switch input PIO slave (s1, data at address 0).

---
 rtl/blinker_pkg.sv | 19 +
 rtl/blinker_poll_timer.sv | 40 ++++
 rtl/blinker_switch_poller.sv | 177 +++++++++++++++++
 tb/tb_blinker_switch_poller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blinker_pkg.sv
// Shared constants for the switch poller: FSM encoding and default tuning values.
package blinker_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_EVAL = 2'd3;

    localparam int DEF_WIDTH            = 8;
    localparam int DEF_POLL_DIV         = 50000;
    localparam int DEF_DEBOUNCE_SAMPLES = 4;
    localparam int DEF_READ_LATENCY     = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blinker_poll_timer.sv
// Reloadable poll-interval down-counter. Load wins over decrement; the count
// parks at zero until the owner reloads it, so a late poll is never lost.
module blinker_poll_timer
    import blinker_pkg::*;
#(
    parameter int RELOAD = DEF_POLL_DIV - 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int TW = cnt_width(RELOAD + 1);

    logic [TW-1:0] count_q, count_d;

    // Next count: reload, count down, or hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = TW'(RELOAD);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    // Counter register, comes out of reset at the reload value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= TW'(RELOAD);
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/blinker_switch_poller.sv
// Avalon-MM master polling the switch PIO, debouncing the samples and
// publishing a stable switch vector with edge pulses and a sticky interrupt.
//
//  state | meaning
//  IDLE  | waiting for timer expiry, pending request or poll_now
//  READ  | one-cycle avm_read strobe
//  WAIT  | remaining read latency (skipped when READ_LATENCY = 1)
//  EVAL  | sample avm_readdata, run debounce, publish edges
module blinker_switch_poller
    import blinker_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int POLL_DIV         = DEF_POLL_DIV,
    parameter int DEBOUNCE_SAMPLES = DEF_DEBOUNCE_SAMPLES,
    parameter int READ_LATENCY     = DEF_READ_LATENCY
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             poll_now,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] sw_state,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_valid,
    output logic             irq
);

    localparam int WW = cnt_width(READ_LATENCY);
    localparam int SW = cnt_width(DEBOUNCE_SAMPLES);

    logic [1:0]       state_q, state_d;
    logic             pending_q, pending_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic [WIDTH-1:0] sw_state_q, sw_state_d;
    logic [WIDTH-1:0] sw_rise_q, sw_rise_d;
    logic [WIDTH-1:0] sw_fall_q, sw_fall_d;
    logic             sw_valid_q, sw_valid_d;
    logic             irq_q, irq_d;
    logic             start;
    logic             timer_expired;
    logic [WIDTH-1:0] sample;
    logic             unused_readdata;

    // Upper PIO bits carry nothing for this block.
    assign unused_readdata = ^avm_readdata[31:WIDTH];
    assign sample          = avm_readdata[WIDTH-1:0];

    // The timer keeps running through a transaction so poll starts stay
    // POLL_DIV apart; with enable low it sits at its reload value.
    blinker_poll_timer #(
        .RELOAD (POLL_DIV - 1)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start || !enable),
        .dec     (enable),
        .expired (timer_expired)
    );

    // FSM, request capture, debounce and edge/irq next-state logic.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        wait_d     = wait_q;
        cand_d     = cand_q;
        stable_d   = stable_q;
        sw_state_d = sw_state_q;
        sw_valid_d = sw_valid_q;
        sw_rise_d  = '0;
        sw_fall_d  = '0;
        irq_d      = irq_q;
        start      = 1'b0;

        // Requests arriving while busy collapse into a single pending poll.
        if ((state_q != ST_IDLE) && poll_now) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((enable && timer_expired) || pending_q || poll_now) begin
                    start     = 1'b1;
                    pending_d = 1'b0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (READ_LATENCY > 1) begin
                    wait_d  = WW'(READ_LATENCY - 2);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_EVAL;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_EVAL;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (sample == cand_q) begin
                    if (int'(stable_q) < DEBOUNCE_SAMPLES - 1) begin
                        stable_d = stable_q + SW'(1);
                    end
                end else begin
                    cand_d   = sample;
                    stable_d = '0;
                end
                if (int'(stable_d) + 1 >= DEBOUNCE_SAMPLES) begin
                    // First accepted value only initialises; it is not a change.
                    if (!sw_valid_q) begin
                        sw_state_d = cand_d;
                        sw_valid_d = 1'b1;
                    end else if (cand_d != sw_state_q) begin
                        sw_rise_d  = cand_d & ~sw_state_q;
                        sw_fall_d  = ~cand_d & sw_state_q;
                        sw_state_d = cand_d;
                    end
                end
            end
        endcase

        // A new masked edge beats an acknowledge in the same cycle.
        if (irq_ack) begin
            irq_d = 1'b0;
        end
        if (((sw_rise_d | sw_fall_d) & irq_mask) != '0) begin
            irq_d = 1'b1;
        end
    end

    // State registers; reset aborts any transaction and drops avm_read at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            wait_q     <= '0;
            cand_q     <= '0;
            stable_q   <= '0;
            sw_state_q <= '0;
            sw_rise_q  <= '0;
            sw_fall_q  <= '0;
            sw_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            wait_q     <= wait_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            sw_state_q <= sw_state_d;
            sw_rise_q  <= sw_rise_d;
            sw_fall_q  <= sw_fall_d;
            sw_valid_q <= sw_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign avm_address = 2'd0;
    assign avm_read    = (state_q == ST_READ);
    assign sw_state    = sw_state_q;
    assign sw_rise     = sw_rise_q;
    assign sw_fall     = sw_fall_q;
    assign sw_valid    = sw_valid_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_blinker_switch_poller.sv
// Directed bench for blinker_switch_poller with POLL_DIV=8, 3-sample debounce
// and a one-cycle-latency PIO model.
module tb_blinker_switch_poller;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic             poll_now;
    logic [1:0]       avm_address;
    logic             avm_read;
    logic [31:0]      avm_readdata;
    logic [WIDTH-1:0] irq_mask;
    logic             irq_ack;
    logic [WIDTH-1:0] sw_state;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_valid;
    logic             irq;

    logic [7:0] in_port;
    int         cyc;
    int         read_cnt;
    int         last_read_cyc;
    int         passed;
    int         total;

    blinker_switch_poller #(
        .WIDTH            (WIDTH),
        .POLL_DIV         (8),
        .DEBOUNCE_SAMPLES (3),
        .READ_LATENCY     (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .poll_now     (poll_now),
        .avm_address  (avm_address),
        .avm_read     (avm_read),
        .avm_readdata (avm_readdata),
        .irq_mask     (irq_mask),
        .irq_ack      (irq_ack),
        .sw_state     (sw_state),
        .sw_rise      (sw_rise),
        .sw_fall      (sw_fall),
        .sw_valid     (sw_valid),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch PIO: data valid the cycle after the read strobe, junk in upper bits.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) avm_readdata <= 32'h0;
        else if (avm_read) avm_readdata <= {24'hABCDEF, in_port};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_read === 1'b1) read_cnt <= read_cnt + 1;
    end

    // Returns at the negedge two cycles after the read strobe, when the
    // debounced outputs of that poll are visible.
    task automatic do_poll(input logic [7:0] v, input bit ack_in_eval);
        bit ok;
        ok = 1'b0;
        in_port = v;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (avm_read === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            $display("FAIL poll_timeout: no avm_read within 40 cycles, want one");
            return;
        end
        last_read_cyc = cyc;
        @(negedge clk);
        if (ack_in_eval) irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        int rc0;
        reset_n = 1'b0; enable = 1'b1; poll_now = 1'b1; irq_ack = 1'b1;
        in_port = 8'hFF; irq_mask = 8'hFF;
        repeat (3) @(negedge clk);
        total++;
        if ({avm_read, avm_address} !== 3'b000) $display("FAIL reset_avm: got read=%b addr=%h want 0/0", avm_read, avm_address);
        else passed++;
        total++;
        if ({sw_state, sw_rise, sw_fall, sw_valid, irq} !== 26'h0) $display("FAIL reset_outputs: got state=%h rise=%h fall=%h valid=%b irq=%b want all 0", sw_state, sw_rise, sw_fall, sw_valid, irq);
        else passed++;
        poll_now = 1'b0; irq_ack = 1'b0; enable = 1'b0;
        reset_n = 1'b1;
        rc0 = read_cnt;
        repeat (20) @(negedge clk);
        total++;
        if (read_cnt !== rc0) $display("FAIL disabled_no_reads: got %0d reads want 0", read_cnt - rc0);
        else passed++;
    endtask

    task automatic test_steady();
        int first_cyc;
        enable = 1'b1;
        do_poll(8'hA5, 1'b0);
        first_cyc = last_read_cyc;
        total++;
        if (sw_valid !== 1'b0) $display("FAIL steady_early_valid: got %b want 0", sw_valid);
        else passed++;
        do_poll(8'hA5, 1'b0);
        total++;
        if (last_read_cyc - first_cyc !== 8) $display("FAIL poll_period: got %0d want 8", last_read_cyc - first_cyc);
        else passed++;
        do_poll(8'hA5, 1'b0);
        total++;
        if ({sw_valid, sw_state} !== 9'h1A5) $display("FAIL steady_accept: got valid=%b state=%h want 1/a5", sw_valid, sw_state);
        else passed++;
        total++;
        if ({sw_rise, sw_fall, irq} !== 17'h0) $display("FAIL steady_no_edges: got rise=%h fall=%h irq=%b want 0", sw_rise, sw_fall, irq);
        else passed++;
    endtask

    task automatic test_change();
        do_poll(8'h5A, 1'b0);
        do_poll(8'h5A, 1'b0);
        total++;
        if (sw_state !== 8'hA5) $display("FAIL change_early: got %h want a5", sw_state);
        else passed++;
        do_poll(8'h5A, 1'b0);
        total++;
        if ({sw_state, sw_rise, sw_fall, irq} !== {8'h5A, 8'h5A, 8'hA5, 1'b1}) $display("FAIL change_edges: got state=%h rise=%h fall=%h irq=%b want 5a/5a/a5/1", sw_state, sw_rise, sw_fall, irq);
        else passed++;
        @(negedge clk);
        total++;
        if ({sw_rise, sw_fall, irq} !== {16'h0, 1'b1}) $display("FAIL change_pulse_width: got rise=%h fall=%h irq=%b want 0/0/1", sw_rise, sw_fall, irq);
        else passed++;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        total++;
        if (irq !== 1'b0) $display("FAIL irq_ack_clear: got %b want 0", irq);
        else passed++;
    endtask

    task automatic test_bounce();
        logic [7:0] pat [4];
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hA5; pat[3] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            do_poll(pat[i], 1'b0);
            total++;
            if ({sw_state, sw_rise, sw_fall} !== {8'h5A, 16'h0}) $display("FAIL bounce_%0d: got state=%h rise=%h fall=%h want 5a/0/0", i, sw_state, sw_rise, sw_fall);
            else passed++;
        end
        irq_mask = 8'h00;
        repeat (3) do_poll(8'h3C, 1'b0);
        total++;
        if ({sw_state, sw_rise, sw_fall, irq} !== {8'h3C, 8'h24, 8'h42, 1'b0}) $display("FAIL masked_change: got state=%h rise=%h fall=%h irq=%b want 3c/24/42/0", sw_state, sw_rise, sw_fall, irq);
        else passed++;
    endtask

    task automatic test_ack_collision();
        irq_mask = 8'hFF;
        do_poll(8'hC3, 1'b0);
        do_poll(8'hC3, 1'b0);
        do_poll(8'hC3, 1'b1);
        total++;
        if ({sw_rise, sw_fall, irq} !== {8'hC3, 8'h3C, 1'b1}) $display("FAIL ack_collision: got rise=%h fall=%h irq=%b want c3/3c/1", sw_rise, sw_fall, irq);
        else passed++;
        @(negedge clk);
        total++;
        if (irq !== 1'b1) $display("FAIL ack_collision_hold: got %b want 1", irq);
        else passed++;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic test_poll_now();
        int rc0;
        enable = 1'b0;
        repeat (12) @(negedge clk);
        rc0 = read_cnt;
        poll_now = 1'b1;
        @(negedge clk);
        total++;
        if (avm_read !== 1'b1) $display("FAIL poll_now_start: got avm_read=%b want 1", avm_read);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        poll_now = 1'b0;
        repeat (30) @(negedge clk);
        total++;
        if (read_cnt - rc0 !== 2) $display("FAIL poll_now_reads: got %0d want 2", read_cnt - rc0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int rel;
        bit ok;
        ok = 1'b0;
        in_port = 8'hA5;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (avm_read === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) $display("FAIL mid_read_timeout: no avm_read within 40 cycles, want one");
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if ({avm_read, sw_valid, sw_state} !== 10'h0) $display("FAIL mid_reset_abort: got read=%b valid=%b state=%h want 0/0/00", avm_read, sw_valid, sw_state);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        do_poll(8'hA5, 1'b0);
        total++;
        if (last_read_cyc - rel !== 8) $display("FAIL restart_first_read: got %0d cycles want 8", last_read_cyc - rel);
        else passed++;
        do_poll(8'hA5, 1'b0);
        do_poll(8'hA5, 1'b0);
        total++;
        if ({sw_valid, sw_state, sw_rise, sw_fall, irq} !== {1'b1, 8'hA5, 17'h0}) $display("FAIL restart_accept: got valid=%b state=%h rise=%h fall=%h irq=%b want 1/a5/0/0/0", sw_valid, sw_state, sw_rise, sw_fall, irq);
        else passed++;
    endtask

    initial begin
        cyc = 0; read_cnt = 0; last_read_cyc = 0; passed = 0; total = 0;
        reset_n = 1'b0; enable = 1'b0; poll_now = 1'b0; irq_ack = 1'b0;
        irq_mask = 8'h00; in_port = 8'h00;
        test_reset();
        test_steady();
        test_change();
        test_bounce();
        test_ack_collision();
        test_poll_now();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
